demux32_8: RTL and testbench
============================

DEMUX32_8 -- requirements
Module: demux32_8

Interface
REQ-001 SHALL: clk_4f  input  1  byte-rate clock; all state updates on the rising edge.
REQ-002 SHALL: reset_L  input  1  asynchronous, active-low reset.
REQ-003 SHALL: data_in  input  32  word to serialize; byte 3 = data_in[31:24] is sent first.
REQ-004 SHALL: valid_in  input  1  data_in holds a word this cycle.
REQ-005 SHALL: ready_out  output  1  block can accept a word; transfer occurs on a rising edge with valid_in=1 and ready_out=1.
REQ-006 SHALL: data_out  output  8  serialized byte, registered.
REQ-007 SHALL: valid_out  output  1  data_out carries a valid byte, registered.
REQ-008 SHALL: last_out  output  1  data_out is byte 0 (final byte) of a word, registered.

Function
REQ-009 SHALL: internal storage is a 32-bit shift register with a 2-bit remaining-byte count (rem), plus a 32-bit holding register with a hold_valid flag.
REQ-010 SHALL: states: IDLE (rem=0, hold empty), SEND (rem>0 or byte in flight, hold empty), SEND_HOLD (hold full).
REQ-011 SHALL: ready_out = NOT hold_valid, driven from registered state only, with no combinational path from valid_in.
REQ-012 SHALL: priority per edge: (1) rem>0 -> emit next byte, rem-1; (2) else hold_valid -> emit hold[31:24], load hold[23:0] into the shifter, rem=3, clear hold_valid; (3) else accepted word -> emit data_in[31:24] directly, load data_in[23:0], rem=3; (4) else valid_out=0, last_out=0.
REQ-013 SHALL: a word accepted while case (1) applies is written to the holding register and hold_valid set.
REQ-014 SHALL: latency: a word accepted in IDLE at edge N has byte 3 on data_out after edge N, then bytes 2, 1, 0 after edges N+1..N+3.
REQ-015 SHALL: words accepted one every 4 cycles produce a gap-free byte stream with valid_out continuously 1.
REQ-016 SHALL: last_out=1 exactly on the cycle data_out carries byte 0; otherwise 0.
REQ-017 SHALL: with hold full, ready_out=0 and valid_in is ignored, with no data loss or overwrite.
REQ-018 SHALL: when rem=0 and hold empty, a word arriving one cycle after the previous byte 0 is emitted immediately per REQ-012(3) with no idle cycle.
REQ-019 SHALL: when valid_out=0, data_out holds the value defined in REQ-024/025.

Reset
REQ-020 SHALL: while reset_L=0, data_out=8'h00 (8'hBC with IDLE_BC_EN), valid_out=0, last_out=0, ready_out=0, rem=0, hold_valid=0, state=IDLE.
REQ-021 SHALL: ready_out rises on the first rising edge after reset_L deasserts.
REQ-022 SHALL: reset asserted mid-word discards all in-flight and held bytes immediately, without waiting for a clock edge.

Configuration
REQ-023 SHALL: macro IDLE_BC_EN selects the idle-byte value.
REQ-024 SHALL: with IDLE_BC_EN defined, data_out=8'hBC whenever valid_out=0, including during reset.
REQ-025 SHALL: without IDLE_BC_EN, data_out=8'h00 whenever valid_out=0.

Verification
REQ-026 SHALL: single word: reset release, then accept 32'hDEADBEEF in IDLE -> data_out DE, AD, BE, EF on 4 consecutive cycles; valid_out=1 for those 4 cycles; last_out=1 only with EF; then valid_out=0.
REQ-027 SHALL: back-to-back words: valid_in held 1 with 32'h01020304 then 32'hA1A2A3A4 -> 8 contiguous valid bytes 01..04, A1..A4; ready_out=0 while hold is full.
REQ-028 SHALL: hold stall: offer 3 words with valid_in held 1 -> the third word is accepted only after ready_out reasserts; 12 bytes output in order with none lost.
REQ-029 SHALL: reset mid-word: pull reset_L low after byte 8'h02 of 32'h01020304 -> valid_out=0 immediately; after release, 32'h11223344 outputs 11, 22, 33, 44 only.
REQ-030 SHALL: idle value: idle for 5 cycles -> data_out=8'hBC with IDLE_BC_EN, 8'h00 without.
REQ-031 SHALL: gap check: one word every 4 cycles (32'h00000000, 32'hFFFFFFFF) -> valid_out never drops between words; last_out every 4th byte.

Source files
------------

// File: rtl/demux32_8.sv
// ---------------------------------------------------------------------------
// demux32_8 : 32-bit word to 8-bit byte serializer.
//
// Each accepted word is sent as four bytes, most significant byte first. A
// one-word holding register lets the next word be taken while the current
// one is still going out, so words offered back to back leave as a
// continuous byte stream.
//
// Handshake: a word moves into the block on a rising clk_4f edge where
// valid_in=1 and ready_out=1. ready_out is a flop and never depends on
// valid_in in the same cycle. Once a word is offered, data_in and valid_in
// stay stable until it is taken. On the output side every cycle with
// valid_out=1 carries one byte; there is no back-pressure.
//
// Ports:
//   clk_4f     in   1  byte-rate clock, rising edge
//   reset_L    in   1  asynchronous reset, active low
//   data_in    in  32  word to serialize, data_in[31:24] goes out first
//   valid_in   in   1  data_in holds a word this cycle
//   ready_out  out  1  block can accept a word this cycle
//   data_out   out  8  serialized byte (idle byte when valid_out=0)
//   valid_out  out  1  data_out carries a byte
//   last_out   out  1  data_out is byte 0 of its word
//   state_dbg  out  2  current FSM state (0 IDLE, 1 SEND, 2 SEND_HOLD)
//
// Configuration macro: IDLE_BC_EN -- when defined, the idle byte is 8'hBC
// instead of 8'h00. It applies during reset as well.
// ---------------------------------------------------------------------------
module demux32_8 (
    input  logic        clk_4f,
    input  logic        reset_L,
    input  logic [31:0] data_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic [7:0]  data_out,
    output logic        valid_out,
    output logic        last_out,
    output logic [1:0]  state_dbg
);

`ifdef IDLE_BC_EN
    localparam logic [7:0] IDLE_BYTE = 8'hBC;
`else
    localparam logic [7:0] IDLE_BYTE = 8'h00;
`endif

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        SEND_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_n;
    logic [31:0] shift_q, shift_n;
    logic [1:0]  rem_q, rem_n;
    logic [31:0] hold_q, hold_n;
    logic        hold_v_q, hold_v_n;
    logic        ready_q, ready_n;
    logic [7:0]  dout_q, dout_n;
    logic        vout_q, vout_n;
    logic        last_q, last_n;
    logic        accept;

    assign accept = valid_in & ready_q;

    always_comb begin
        shift_n  = shift_q;
        rem_n    = rem_q;
        hold_n   = hold_q;
        hold_v_n = hold_v_q;
        dout_n   = IDLE_BYTE;
        vout_n   = 1'b0;
        last_n   = 1'b0;

        if (rem_q != 2'd0) begin
            // Bytes of the current word still pending in the shifter.
            dout_n  = shift_q[31:24];
            shift_n = {shift_q[23:0], 8'h00};
            rem_n   = rem_q - 2'd1;
            vout_n  = 1'b1;
            last_n  = (rem_q == 2'd1);
            if (accept) begin
                hold_n   = data_in;
                hold_v_n = 1'b1;
            end
        end else if (hold_v_q) begin
            // Held word starts straight away; ready_q is low here so no
            // new word can arrive on this edge.
            dout_n   = hold_q[31:24];
            shift_n  = {hold_q[23:0], 8'h00};
            rem_n    = 2'd3;
            hold_v_n = 1'b0;
            vout_n   = 1'b1;
        end else if (accept) begin
            // Nothing pending: the first byte bypasses the shifter.
            dout_n  = data_in[31:24];
            shift_n = {data_in[23:0], 8'h00};
            rem_n   = 2'd3;
            vout_n  = 1'b1;
        end

        ready_n = ~hold_v_n;

        if (hold_v_n)
            state_n = SEND_HOLD;
        else if ((rem_n != 2'd0) || vout_n)
            state_n = SEND;
        else
            state_n = IDLE;
    end

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state_q  <= IDLE;
            shift_q  <= 32'h0;
            rem_q    <= 2'd0;
            hold_q   <= 32'h0;
            hold_v_q <= 1'b0;
            ready_q  <= 1'b0;
            dout_q   <= IDLE_BYTE;
            vout_q   <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            shift_q  <= shift_n;
            rem_q    <= rem_n;
            hold_q   <= hold_n;
            hold_v_q <= hold_v_n;
            ready_q  <= ready_n;
            dout_q   <= dout_n;
            vout_q   <= vout_n;
            last_q   <= last_n;
        end
    end

    assign ready_out = ready_q;
    assign data_out  = dout_q;
    assign valid_out = vout_q;
    assign last_out  = last_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_demux32_8.sv
// ---------------------------------------------------------------------------
// tb_demux32_8 : self-checking bench for demux32_8.
// Directed words; expected bytes are written by hand into exp_q and a
// negedge monitor pops and compares every valid output byte.
// ---------------------------------------------------------------------------
module tb_demux32_8;

`ifdef IDLE_BC_EN
    localparam logic [7:0] IDLE_BYTE = 8'hBC;
`else
    localparam logic [7:0] IDLE_BYTE = 8'h00;
`endif

    logic        clk_4f;
    logic        reset_L;
    logic [31:0] data_in;
    logic        valid_in;
    logic        ready_out;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        last_out;
    logic [1:0]  state_dbg;

    logic [8:0]  exp_q[$];   // {last, byte}
    int          checks;
    int          fails;
    int          cyc;
    logic        gap_watch;

    demux32_8 dut (
        .clk_4f    (clk_4f),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .last_out  (last_out),
        .state_dbg (state_dbg)
    );

    // clock / cycle counter
    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;
    always @(posedge clk_4f) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic exp4(input logic [7:0] b3, input logic [7:0] b2,
                        input logic [7:0] b1, input logic [7:0] b0);
        exp_q.push_back({1'b0, b3});
        exp_q.push_back({1'b0, b2});
        exp_q.push_back({1'b0, b1});
        exp_q.push_back({1'b1, b0});
    endtask

    // Offer a word; returns after the accepting edge, with the cycle number
    // of that edge. valid_in is left high for back-to-back use.
    task automatic send(input logic [31:0] w, output int acc_cyc);
        bit done;
        done = 0;
        acc_cyc = -1;
        @(negedge clk_4f);
        valid_in = 1'b1;
        data_in  = w;
        for (int i = 0; i < 50; i++) begin
            if (ready_out) begin
                acc_cyc = cyc;
                @(posedge clk_4f);
                done = 1;
                break;
            end
            @(negedge clk_4f);
        end
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: word %h not accepted within 50 cycles", w);
        end
    endtask

    task automatic idle_in();
        @(negedge clk_4f);
        valid_in = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk_4f);
            n++;
        end
        @(negedge clk_4f);
        @(negedge clk_4f);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    // monitor / scoreboard
    always @(negedge clk_4f) begin
        if (reset_L) begin
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_byte: got %h last %b, expected nothing", data_out, last_out);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("byte", {23'h0, last_out, data_out}, {23'h0, e});
                end
            end else begin
                check("idle_byte", {24'h0, data_out}, {24'h0, IDLE_BYTE});
                check("idle_last", {31'h0, last_out}, 32'h0);
                if (gap_watch) begin
                    checks++;
                    fails++;
                    $display("FAIL gap: valid_out got 0 expected 1 during gap-free stream");
                end
            end
        end
    end

    initial begin
        int a1, a2, a3;
        checks = 0; fails = 0; cyc = 0; gap_watch = 1'b0;
        reset_L = 1'b0; valid_in = 1'b0; data_in = 32'h0;

        // reset state
        repeat (3) @(negedge clk_4f);
        check("rst_data",  {24'h0, data_out}, {24'h0, IDLE_BYTE});
        check("rst_valid", {31'h0, valid_out}, 32'h0);
        check("rst_last",  {31'h0, last_out}, 32'h0);
        check("rst_ready", {31'h0, ready_out}, 32'h0);
        check("rst_state", {30'h0, state_dbg}, 32'h0);
        reset_L = 1'b1;
        #1 check("ready_before_edge", {31'h0, ready_out}, 32'h0);
        @(posedge clk_4f);
        #1 check("ready_after_edge", {31'h0, ready_out}, 32'h1);

        // single word
        exp4(8'hDE, 8'hAD, 8'hBE, 8'hEF);
        send(32'hDEADBEEF, a1);
        idle_in();
        drain("single");

        // back-to-back pair; hold full right after the second accept
        exp4(8'h01, 8'h02, 8'h03, 8'h04);
        exp4(8'hA1, 8'hA2, 8'hA3, 8'hA4);
        send(32'h01020304, a1);
        send(32'hA1A2A3A4, a2);
        idle_in();
        check("hold_ready_low", {31'h0, ready_out}, 32'h0);
        check("hold_state", {30'h0, state_dbg}, 32'd2);
        check("pair_accept_gap", a2 - a1, 1);
        drain("pair");

        // three words: third waits for the hold register to empty
        exp4(8'h12, 8'h34, 8'h56, 8'h78);
        exp4(8'h9A, 8'hBC, 8'hDE, 8'hF0);
        exp4(8'h0F, 8'h1E, 8'h2D, 8'h3C);
        send(32'h12345678, a1);
        send(32'h9ABCDEF0, a2);
        send(32'h0F1E2D3C, a3);
        idle_in();
        check("stall_accept2", a2 - a1, 1);
        check("stall_accept3", a3 - a1, 5);
        drain("stall");

        // reset mid-word
        exp_q.push_back({1'b0, 8'h01});
        send(32'h01020304, a1);
        @(negedge clk_4f);
        valid_in = 1'b0;
        @(posedge clk_4f);
        #1 check("mid_byte2", {23'h0, valid_out, data_out}, {23'h0, 1'b1, 8'h02});
        reset_L = 1'b0;
        #1 check("mid_rst_valid", {31'h0, valid_out}, 32'h0);
        check("mid_rst_data", {24'h0, data_out}, {24'h0, IDLE_BYTE});
        check("mid_rst_queue", exp_q.size(), 0);
        repeat (2) @(negedge clk_4f);
        reset_L = 1'b1;
        @(posedge clk_4f);
        exp4(8'h11, 8'h22, 8'h33, 8'h44);
        send(32'h11223344, a1);
        idle_in();
        drain("after_reset");

        // idle for 5 cycles
        repeat (5) begin
            @(negedge clk_4f);
            #1 check("idle5", {23'h0, valid_out, data_out}, {23'h0, 1'b0, IDLE_BYTE});
        end

        // one word every 4 cycles: continuous valid_out
        exp4(8'h00, 8'h00, 8'h00, 8'h00);
        exp4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        send(32'h00000000, a1);
        gap_watch = 1'b1;
        idle_in();
        repeat (2) @(negedge clk_4f);
        send(32'hFFFFFFFF, a2);
        check("gap_accept", a2 - a1, 4);
        idle_in();
        repeat (2) @(posedge clk_4f);
        @(negedge clk_4f);
        #1 gap_watch = 1'b0;
        drain("gap");

        check("final_queue", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
